mux_result_uart_tx: RTL and testbench

Downstream consumer of the 8-bit nibble-mux result (C bus). Captures a byte and serialises it onto one pin as an asynchronous 8N1 frame (start, 8 data LSB-first, stop), so the mux output can be observed off-chip on a single uio line. Uses a valid/ready handshake, and can optionally self-trigger whenever C changes.

---
 rtl/mux_result_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_mux_result_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_result_uart_tx.sv
// ============================================================================
// Module   : mux_result_uart_tx
// Brief    : 8N1 UART transmitter for the nibble-mux C bus. Handshakes with
//            valid/ready and can optionally self-trigger on data changes.
//            Optional macro UART_PARITY_EN adds an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit AUTO_SEND    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data_in,
    input  logic       i_start,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_done;

    logic             w_auto_trig;
    logic             w_accept;
    logic             w_bit_end;
    logic [2:0]       w_next_idx;

    assign w_accept   = (r_state == S_IDLE) && (i_start || w_auto_trig);
    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign w_next_idx = r_bit_idx + 3'd1;

    generate
        if (AUTO_SEND) begin : g_auto_send
            logic [7:0] r_last_sent;
            logic       r_pending;
            logic       w_changed;

            assign w_changed = (i_data_in != r_last_sent);

            // A change seen mid-frame is remembered so it is sent even if C reverts.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_last_sent <= 8'h00;
                    r_pending   <= 1'b0;
                end else if (w_accept) begin
                    r_last_sent <= i_data_in;
                    r_pending   <= 1'b0;
                end else if ((r_state != S_IDLE) && w_changed) begin
                    r_pending   <= 1'b1;
                end
            end

            assign w_auto_trig = w_changed || r_pending;
        end else begin : g_manual_send
            assign w_auto_trig = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= i_data_in;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud  <= r_baud + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= ^r_shift;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud  <= r_baud + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_baud  <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = ~o_ready;
    assign o_tx    = r_tx;
    assign o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mux_result_uart_tx.sv
// ============================================================================
// Module   : tb_mux_result_uart_tx
// Brief    : Directed bench with a frame-decoding scoreboard for a manual-start
//            instance and an AUTO_SEND instance (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_result_uart_tx;

    localparam int N = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0, din1;
    logic       start0, start1;
    logic       ready0, tx0, busy0, done0;
    logic       ready1, tx1, busy1, done1;

    always #5 clk = ~clk;

    mux_result_uart_tx #(.CLKS_PER_BIT(N), .AUTO_SEND(1'b0)) u_dut (
        .clk(clk), .rst(rst), .i_data_in(din0), .i_start(start0),
        .o_ready(ready0), .o_tx(tx0), .o_busy(busy0), .o_done(done0)
    );

    mux_result_uart_tx #(.CLKS_PER_BIT(N), .AUTO_SEND(1'b1)) u_auto (
        .clk(clk), .rst(rst), .i_data_in(din1), .i_start(start1),
        .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line image LSB-first: start, 8 data bits, parity (if any), stop; unused bits idle high.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Scoreboard monitor: decode each frame at mid-bit and compare with queue head.
    int          mcnt   [2];
    bit          mact   [2];
    logic [10:0] mbits  [2];
    int          frames [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mact[i] = 1'b0; mbits[i] = '1; frames[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            logic       t;
            logic       has;
            logic [7:0] e;
            t = (ch == 0) ? tx0 : tx1;
            if (rst) begin
                mact[ch] = 1'b0;
            end else if (!mact[ch]) begin
                if (t == 1'b0) begin
                    mact[ch]  = 1'b1;
                    mcnt[ch]  = 0;
                    mbits[ch] = '1;
                end
            end else begin
                mcnt[ch]++;
            end
            if (mact[ch] && !rst && ((mcnt[ch] % N) == N / 2)) begin
                mbits[ch][mcnt[ch] / N] = t;
                if ((mcnt[ch] / N) == NB - 1) begin
                    mact[ch] = 1'b0;
                    frames[ch]++;
                    e = 8'h00;
                    if (ch == 0) begin
                        has = (q0.size() > 0);
                        if (has) e = q0.pop_front();
                    end else begin
                        has = (q1.size() > 0);
                        if (has) e = q1.pop_front();
                    end
                    chk($sformatf("frame_ch%0d", ch), {20'b0, has, mbits[ch]},
                        {20'b0, 1'b1, frame_of(e)});
                end
            end
        end
    end

    // Called at the negedge of the first cycle after acceptance; returns the
    // cycle number (relative to acceptance) on which ready is seen high.
    task automatic wait_ready(input int ch, output int cyc);
        cyc = 1;
        while ((((ch == 0) ? ready0 : ready1) !== 1'b1) && (cyc < 500)) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int dn;
        int f0;

        din0 = 8'h00; start0 = 1'b0;
        din1 = 8'h00; start1 = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx",    {31'b0, tx0},    32'd1);
        chk("rst_ready", {31'b0, ready0}, 32'd1);
        chk("rst_busy",  {31'b0, busy0},  32'd0);
        chk("rst_done",  {31'b0, done0},  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tx_auto", {31'b0, tx1}, 32'd1);

        // Single 0xA5 frame with one-cycle start.
        din0 = 8'hA5; start0 = 1'b1; q0.push_back(8'hA5);
        @(negedge clk);
        start0 = 1'b0;
        chk("t1_tx_low", {31'b0, tx0},    32'd0);
        chk("t1_busy",   {31'b0, busy0},  32'd1);
        wait_ready(0, cyc);
        chk("t1_ready_cycle", cyc, FLEN + 1);
        chk("t1_done",        {31'b0, done0}, 32'd1);
        @(negedge clk);
        chk("t1_done_1cyc",   {31'b0, done0}, 32'd0);

        // Start held: 0x00 then 0xFF back-to-back.
        din0 = 8'h00; start0 = 1'b1; q0.push_back(8'h00);
        @(negedge clk);
        wait_ready(0, cyc);
        chk("t2_ready_cycle", cyc, FLEN + 1);
        chk("t2_done",        {31'b0, done0}, 32'd1);
        din0 = 8'hFF; q0.push_back(8'hFF);
        @(negedge clk);
        start0 = 1'b0;
        chk("t2_no_gap_tx",    {31'b0, tx0},    32'd0);
        chk("t2_no_gap_ready", {31'b0, ready0}, 32'd0);
        wait_ready(0, cyc);
        chk("t2b_ready_cycle", cyc, FLEN + 1);
        @(negedge clk);

        // Mid-frame data change and start pulse are ignored.
        f0 = frames[0];
        dn = 0;
        din0 = 8'hC3; start0 = 1'b1; q0.push_back(8'hC3);
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 1; i < FLEN + 20; i++) begin
            if (i == 10) begin
                din0 = 8'h3C; start0 = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            dn += int'(done0);
            @(negedge clk);
        end
        chk("t3_done_pulses", dn, 1);
        chk("t3_frames",      frames[0] - f0, 1);
        chk("t3_ready",       {31'b0, ready0}, 32'd1);

        // Reset at cycle 15 aborts the frame; restart immediately afterwards.
        din0 = 8'h5A; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_tx",    {31'b0, tx0},    32'd1);
        chk("t4_ready", {31'b0, ready0}, 32'd1);
        chk("t4_busy",  {31'b0, busy0},  32'd0);
        chk("t4_done",  {31'b0, done0},  32'd0);
        rst = 1'b0;
        din0 = 8'h81; start0 = 1'b1; q0.push_back(8'h81);
        @(negedge clk);
        start0 = 1'b0;
        chk("t4_restart_tx", {31'b0, tx0}, 32'd0);
        wait_ready(0, cyc);
        chk("t4_ready_cycle", cyc, FLEN + 1);
        @(negedge clk);

        // AUTO_SEND instance: data change triggers, mid-frame change queues one more.
        chk("t5_no_spurious", frames[1], 0);
        din1 = 8'h12; q1.push_back(8'h12);
        @(negedge clk);
        chk("t5_auto_tx_low", {31'b0, tx1}, 32'd0);
        repeat (19) @(negedge clk);
        din1 = 8'h34; q1.push_back(8'h34);
        cyc = 0;
        while ((ready1 !== 1'b1) && (cyc < 500)) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_done",          {31'b0, done1},  32'd1);
        @(negedge clk);
        chk("t5_pending_ready", {31'b0, ready1}, 32'd0);
        chk("t5_pending_tx",    {31'b0, tx1},    32'd0);
        wait_ready(1, cyc);
        chk("t5b_ready_cycle", cyc, FLEN + 1);
        repeat (FLEN + 10) @(negedge clk);
        chk("t5_frames", frames[1], 2);
        chk("t5_idle",   {31'b0, ready1}, 32'd1);

`ifdef UART_PARITY_EN
        // Parity: 0x07 has odd weight (parity 1), 0x03 even (parity 0).
        din0 = 8'h07; start0 = 1'b1; q0.push_back(8'h07);
        @(negedge clk);
        start0 = 1'b0;
        chk("p1_parity_bit", {31'b0, ^din0}, 32'd1);
        wait_ready(0, cyc);
        chk("p1_ready_cycle", cyc, 11 * N + 1);
        @(negedge clk);
        din0 = 8'h03; start0 = 1'b1; q0.push_back(8'h03);
        @(negedge clk);
        start0 = 1'b0;
        wait_ready(0, cyc);
        chk("p2_ready_cycle", cyc, 11 * N + 1);
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("sb_q0_empty", q0.size(), 0);
        chk("sb_q1_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
